alu_result_queue: RTL and testbench

//  Consumer end of the ALU result interface.
//  - Captures each result the ALU marks valid through check_queue: value, destination register, write enable, PC redirect.
//  - Buffers results in an in-order FIFO and drains them to writeback under a valid/ready handshake.
//  - Converts a drained jr-type entry (change_pc) into a registered redirect pulse and squashes all younger queued results.

---
 rtl/alu_result_queue.sv | 183 ++++++++++++++++++
 tb/tb_alu_result_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
// In-order result queue between the ALU check_queue port and writeback; a drained jr entry
// raises a registered redirect pulse and squashes younger results. RQ_BYPASS_EN enables an empty-queue bypass.
`ifndef DWIDTH
`define DWIDTH 32
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rq_i_valid,
  input  logic [`DWIDTH-1:0]   rq_i_value,
  input  logic [4:0]           rq_i_rd,
  input  logic                 rq_i_we,
  input  logic                 rq_i_change_pc,
  input  logic [`PC_WIDTH-1:0] rq_i_pc,
  input  logic                 rq_i_flush,
  output logic                 rq_o_ready,
  output logic                 rq_o_valid,
  output logic [`DWIDTH-1:0]   rq_o_value,
  output logic [4:0]           rq_o_rd,
  output logic                 rq_o_we,
  input  logic                 rq_i_wb_ready,
  output logic                 rq_o_redirect,
  output logic [`PC_WIDTH-1:0] rq_o_redirect_pc,
  output logic [PTR_W:0]       rq_o_count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [`DWIDTH-1:0]   val_q [DEPTH];
  logic [4:0]           rd_q  [DEPTH];
  logic                 we_q  [DEPTH];
  logic                 cp_q  [DEPTH];
  logic [`PC_WIDTH-1:0] pc_q  [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 redirect_q, redirect_d;
  logic [`PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic                 in_we_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 store_s;
  logic                 pop_store_s;
  logic                 head_cp_s;
  logic [`PC_WIDTH-1:0] head_pc_s;
  logic                 write_en_s;

  // Effective write enable: jr entries and writes to x0 never update the register file.
  assign in_we_s    = rq_i_we & ~rq_i_change_pc & (rq_i_rd != 5'd0);
  assign rq_o_ready = (count_q != CNT_FULL);
  assign push_s     = rq_i_valid & rq_o_ready;
  assign pop_s      = rq_o_valid & rq_i_wb_ready;

`ifdef RQ_BYPASS_EN
  logic bypass_s;
  assign bypass_s = (count_q == '0) & rq_i_valid;

  // Head selection: an empty queue forwards the incoming result straight through.
  always_comb begin
    if (bypass_s) begin
      rq_o_valid = 1'b1;
      rq_o_value = rq_i_value;
      rq_o_rd    = rq_i_rd;
      rq_o_we    = in_we_s;
      head_cp_s  = rq_i_change_pc;
      head_pc_s  = rq_i_pc;
    end else begin
      rq_o_valid = (count_q != '0);
      rq_o_value = val_q[rd_ptr_q];
      rq_o_rd    = rd_q[rd_ptr_q];
      rq_o_we    = we_q[rd_ptr_q];
      head_cp_s  = cp_q[rd_ptr_q];
      head_pc_s  = pc_q[rd_ptr_q];
    end
  end

  assign store_s     = push_s & ~(bypass_s & rq_i_wb_ready);
  assign pop_store_s = pop_s & ~bypass_s;
`else
  // Head selection: presented only from stored state, so push-to-head latency is one cycle.
  always_comb begin
    rq_o_valid = (count_q != '0);
    rq_o_value = val_q[rd_ptr_q];
    rq_o_rd    = rd_q[rd_ptr_q];
    rq_o_we    = we_q[rd_ptr_q];
    head_cp_s  = cp_q[rd_ptr_q];
    head_pc_s  = pc_q[rd_ptr_q];
  end

  assign store_s     = push_s;
  assign pop_store_s = pop_s;
`endif

  // Next-state: flush beats a jr squash, which beats ordinary push/pop traffic.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    write_en_s    = 1'b0;
    if (rq_i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (pop_s && head_cp_s) begin
      redirect_d    = 1'b1;
      redirect_pc_d = head_pc_s;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
    end else begin
      write_en_s = store_s;
      if (store_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_store_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({store_s, pop_store_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_q[i] <= '0;
        rd_q[i]  <= '0;
        we_q[i]  <= 1'b0;
        cp_q[i]  <= 1'b0;
        pc_q[i]  <= '0;
      end
    end else if (write_en_s) begin
      val_q[wr_ptr_q] <= rq_i_value;
      rd_q[wr_ptr_q]  <= rq_i_rd;
      we_q[wr_ptr_q]  <= in_we_s;
      cp_q[wr_ptr_q]  <= rq_i_change_pc;
      pc_q[wr_ptr_q]  <= rq_i_pc;
    end
  end

  assign rq_o_redirect    = redirect_q;
  assign rq_o_redirect_pc = redirect_pc_q;
  assign rq_o_count       = count_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue in its default (non-bypass) build, DEPTH=4.
module tb_alu_result_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq_i_valid, rq_i_we, rq_i_change_pc, rq_i_flush, rq_i_wb_ready;
  logic [31:0] rq_i_value, rq_i_pc;
  logic [4:0]  rq_i_rd;
  logic        rq_o_ready, rq_o_valid, rq_o_we, rq_o_redirect;
  logic [31:0] rq_o_value, rq_o_redirect_pc;
  logic [4:0]  rq_o_rd;
  logic [2:0]  rq_o_count;

  always #5 clk = ~clk;

  alu_result_queue dut (
    .clk(clk), .rst(rst),
    .rq_i_valid(rq_i_valid), .rq_i_value(rq_i_value), .rq_i_rd(rq_i_rd),
    .rq_i_we(rq_i_we), .rq_i_change_pc(rq_i_change_pc), .rq_i_pc(rq_i_pc),
    .rq_i_flush(rq_i_flush), .rq_o_ready(rq_o_ready), .rq_o_valid(rq_o_valid),
    .rq_o_value(rq_o_value), .rq_o_rd(rq_o_rd), .rq_o_we(rq_o_we),
    .rq_i_wb_ready(rq_i_wb_ready), .rq_o_redirect(rq_o_redirect),
    .rq_o_redirect_pc(rq_o_redirect_pc), .rq_o_count(rq_o_count)
  );

  typedef struct {
    logic        v;
    logic [31:0] val;
    logic [4:0]  rd;
    logic        we, cp;
    logic [31:0] pc;
    logic        fl, wb;
    logic        e_rdy, e_vld;
    logic [31:0] e_val;
    logic [4:0]  e_rd;
    logic        e_we, e_redir;
    logic [31:0] e_rpc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] val, input logic [4:0] rd, input logic we,
                     input logic cp, input logic [31:0] pc, input logic fl, input logic wb,
                     input logic e_rdy, input logic e_vld, input logic [31:0] e_val,
                     input logic [4:0] e_rd, input logic e_we, input logic e_redir,
                     input logic [31:0] e_rpc, input logic [2:0] e_cnt);
    vec_t t;
    t.v = v; t.val = val; t.rd = rd; t.we = we; t.cp = cp; t.pc = pc; t.fl = fl; t.wb = wb;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_val = e_val; t.e_rd = e_rd; t.e_we = e_we;
    t.e_redir = e_redir; t.e_rpc = e_rpc; t.e_cnt = e_cnt;
    vq.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [31:0] val, input logic [4:0] rd, input logic we,
                       input logic cp, input logic [31:0] pc, input logic fl, input logic wb);
    rq_i_valid = v; rq_i_value = val; rq_i_rd = rd; rq_i_we = we;
    rq_i_change_pc = cp; rq_i_pc = pc; rq_i_flush = fl; rq_i_wb_ready = wb;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Each row: inputs held for one cycle | outputs expected during that cycle.
    // single push with immediate drain
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 3'd0);
    add(1'b1, 32'h05, 5'd3, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 3'd0);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'h05, 5'd3, 1'b1, 1'b0, 32'h00, 3'd1);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 3'd0);
    // fill past capacity, fifth push dropped
    add(1'b1, 32'h01, 5'd1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 3'd0);
    add(1'b1, 32'h02, 5'd2, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h01, 5'd1, 1'b1, 1'b0, 32'h00, 3'd1);
    add(1'b1, 32'h03, 5'd3, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h01, 5'd1, 1'b1, 1'b0, 32'h00, 3'd2);
    add(1'b1, 32'h04, 5'd4, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h01, 5'd1, 1'b1, 1'b0, 32'h00, 3'd3);
    add(1'b1, 32'h05, 5'd5, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b0, 1'b1, 32'h01, 5'd1, 1'b1, 1'b0, 32'h00, 3'd4);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b0, 1'b1, 32'h01, 5'd1, 1'b1, 1'b0, 32'h00, 3'd4);
    // full: push+pop drops the push; then push+pop at count 2 across the pointer wrap
    add(1'b1, 32'h06, 5'd6, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h01, 5'd1, 1'b1, 1'b0, 32'h00, 3'd4);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h02, 5'd2, 1'b1, 1'b0, 32'h00, 3'd3);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'h02, 5'd2, 1'b1, 1'b0, 32'h00, 3'd3);
    add(1'b1, 32'h07, 5'd7, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'h03, 5'd3, 1'b1, 1'b0, 32'h00, 3'd2);
    add(1'b1, 32'h08, 5'd8, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'h04, 5'd4, 1'b1, 1'b0, 32'h00, 3'd2);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'h07, 5'd7, 1'b1, 1'b0, 32'h00, 3'd2);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'h08, 5'd8, 1'b1, 1'b0, 32'h00, 3'd1);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 3'd0);
    // [add, jr 0x40, add, add]: jr squashes the trailing adds
    add(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 3'd0);
    add(1'b1, 32'h22, 5'd2, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0,  1'b1, 1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 32'h00, 3'd1);
    add(1'b1, 32'h33, 5'd0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 32'h00, 3'd2);
    add(1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 32'h00, 3'd3);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1,  1'b0, 1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 32'h00, 3'd4);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'h22, 5'd2, 1'b0, 1'b0, 32'h00, 3'd3);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b1, 32'h40, 3'd0);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h40, 3'd0);
    // rd==0 forces we low
    add(1'b1, 32'h55, 5'd0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h40, 3'd0);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1,  1'b1, 1'b1, 32'h55, 5'd0, 1'b0, 1'b0, 32'h40, 3'd1);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h40, 3'd0);
    // flush at count 3 with push and pop active
    add(1'b1, 32'h61, 5'd1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h40, 3'd0);
    add(1'b1, 32'h62, 5'd2, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h61, 5'd1, 1'b1, 1'b0, 32'h40, 3'd1);
    add(1'b1, 32'h63, 5'd3, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h61, 5'd1, 1'b1, 1'b0, 32'h40, 3'd2);
    add(1'b1, 32'h64, 5'd4, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1,  1'b1, 1'b1, 32'h61, 5'd1, 1'b1, 1'b0, 32'h40, 3'd3);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h40, 3'd0);
    add(1'b1, 32'h71, 5'd1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h40, 3'd0);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b1, 32'h71, 5'd1, 1'b1, 1'b0, 32'h40, 3'd1);
    // flush while a jr is popped: no redirect, target held
    add(1'b1, 32'h72, 5'd2, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1,  1'b1, 1'b1, 32'h71, 5'd1, 1'b1, 1'b0, 32'h40, 3'd1);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1,  1'b1, 1'b1, 32'h72, 5'd2, 1'b0, 1'b0, 32'h40, 3'd1);
    add(1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0,  1'b1, 1'b0, 32'h00, 5'd0, 1'b0, 1'b0, 32'h40, 3'd0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1 drive(vq[i].v, vq[i].val, vq[i].rd, vq[i].we, vq[i].cp, vq[i].pc, vq[i].fl, vq[i].wb);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(rq_o_ready), 32'(vq[i].e_rdy));
      chk($sformatf("v%0d_valid", i), 32'(rq_o_valid), 32'(vq[i].e_vld));
      chk($sformatf("v%0d_redirect", i), 32'(rq_o_redirect), 32'(vq[i].e_redir));
      chk($sformatf("v%0d_rpc", i), rq_o_redirect_pc, vq[i].e_rpc);
      chk($sformatf("v%0d_count", i), 32'(rq_o_count), 32'(vq[i].e_cnt));
      if (vq[i].e_vld) begin
        chk($sformatf("v%0d_value", i), rq_o_value, vq[i].e_val);
        chk($sformatf("v%0d_rd", i), 32'(rq_o_rd), 32'(vq[i].e_rd));
        chk($sformatf("v%0d_we", i), 32'(rq_o_we), 32'(vq[i].e_we));
      end
    end

    // Asynchronous reset mid-cycle with two entries queued.
    @(posedge clk); #1 drive(1'b1, 32'hA1, 5'd1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1 drive(1'b1, 32'hA2, 5'd2, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", 32'(rq_o_count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst1_count", 32'(rq_o_count), 32'd0);
    chk("rst1_valid", 32'(rq_o_valid), 32'd0);
    chk("rst1_ready", 32'(rq_o_ready), 32'd1);
    chk("rst1_rpc", rq_o_redirect_pc, 32'h0);

    // Asynchronous reset during a redirect pulse.
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b1, 32'hB1, 5'd3, 1'b1, 1'b1, 32'hB0, 1'b0, 1'b0);
    @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pulse_redirect", 32'(rq_o_redirect), 32'd1);
    chk("pulse_rpc", rq_o_redirect_pc, 32'hB0);
    #2 rst = 1'b1;
    #1;
    chk("rst2_redirect", 32'(rq_o_redirect), 32'd0);
    chk("rst2_rpc", rq_o_redirect_pc, 32'h0);
    chk("rst2_ready", 32'(rq_o_ready), 32'd1);

    // Normal push after reset release.
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b1, 32'hC1, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1 drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_valid", 32'(rq_o_valid), 32'd1);
    chk("post_value", rq_o_value, 32'hC1);
    chk("post_rd", 32'(rq_o_rd), 32'd5);
    chk("post_we", 32'(rq_o_we), 32'd1);
    chk("post_count", 32'(rq_o_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
